// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter with a small FIFO in front of the frame
//            engine. Build option UART_TX_PARITY_EN adds an even-parity bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE = CNT_W'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             push, pop, bit_end, buf_nonempty;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign push         = data_valid && ready_q;
    assign bit_end      = (baud_q == BIT_LAST);
    assign buf_nonempty = (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // ready is registered from the next occupancy so it never depends on data_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + BAUD_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (buf_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // back-to-back frames: reload straight into START without an idle cycle
                if (bit_end) begin
                    if (buf_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_d = ^mem_q[rd_ptr_q];
`endif
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = (state_q != ST_IDLE) || buf_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [NBITS-1:0] A5_FRAME = 11'b10101001010;
`else
    localparam int NBITS = 10;
    localparam logic [NBITS-1:0] A5_FRAME = 10'b1101001010;
`endif
    localparam int FRAME = NBITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       ready, tx, busy;

    int checks = 0;
    int failures = 0;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .data_valid(data_valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    // Frame-level model: queue of accepted bytes, remaining cycles of the frame in flight
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h00;
    int         m_left = 0;
    logic       m_tx = 1'b1;
    logic       m_seen = 1'b0;
    logic       m_push = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_left = 0;
            m_tx   = 1'b1;
            m_seen = 1'b0;
            m_push = 1'b0;
        end else begin
            m_tx   = (m_left > 0) ? frame_bit(m_cur, (FRAME - m_left) / BIT_CLKS) : 1'b1;
            m_push = data_valid && m_seen && (m_q.size() < DEPTH);
            if (m_left <= 1 && m_q.size() > 0) begin
                m_cur  = m_q.pop_front();
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end
            if (m_push) m_q.push_back(data);
            m_seen = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic exp_ready, exp_busy;
        exp_ready = m_seen && (m_q.size() < DEPTH);
        exp_busy  = (m_left > 0) || (m_q.size() > 0);
        checks++;
        assert (tx === m_tx) else begin
            failures++;
            $error("FAIL tx_cycle t=%0t observed=%b expected=%b", $time, tx, m_tx);
        end
        checks++;
        assert (ready === exp_ready) else begin
            failures++;
            $error("FAIL ready_cycle t=%0t observed=%b expected=%b", $time, ready, exp_ready);
        end
        checks++;
        assert (busy === exp_busy) else begin
            failures++;
            $error("FAIL busy_cycle t=%0t observed=%b expected=%b", $time, busy, exp_busy);
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit ff_when_full, input int limit);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            data       = (ff_when_full && !(m_seen && m_q.size() < DEPTH)) ? 8'hFF : b;
            data_valid = 1'b1;
            @(posedge clk);
            #1;
            done = m_push;
            n++;
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL push_timeout byte=%h observed_cycles=%0d expected_max=%0d", b, n, limit);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((m_left != 0 || m_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < limit) else begin
            failures++;
            $error("FAIL idle_timeout observed=%0d expected_below=%0d", n, limit);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [NBITS-1:0] a5_bits;
        logic [7:0]       rb;
        int               gap;
        a5_bits = A5_FRAME;

        // reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_ready", ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", ready, 1'b1);

        // single 0xA5: latency and bit pattern
        @(negedge clk);
        data = 8'hA5;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("a5_accepted", m_push, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        data = 8'h00;
        @(posedge clk);
        #1;
        chk("latency_n1_tx", tx, 1'b1);
        @(posedge clk);
        #1;
        chk("latency_n2_tx", tx, 1'b0);
        chk("latency_ready", ready, 1'b1);
        for (int j = 0; j < NBITS; j++) begin
            repeat ((j == 0) ? BIT_CLKS / 2 : BIT_CLKS) @(posedge clk);
            #1;
            chk($sformatf("a5_bit%0d", j), tx, a5_bits[j]);
        end
        repeat (BIT_CLKS - BIT_CLKS / 2 + 1) @(posedge clk);
        #1;
        chk("a5_busy_after", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        data = 8'h01;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (2 + 9 * BIT_CLKS + BIT_CLKS / 2) @(posedge clk);
        #1;
        chk("parity_01", tx, 1'b1);
        wait_idle(2 * FRAME);
`endif

        // burst 0x10..0x17 with data_valid held; 0xFF offered while full
        for (int i = 0; i < 8; i++) begin
            push_byte(8'h10 + 8'(i), 1'b1, 2 * FRAME);
            if (i == 3) chk("burst_ready_after4", ready, 1'b1);
            if (i == 4) chk("burst_ready_after5", ready, 1'b0);
        end
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle(9 * FRAME);
        @(negedge clk);
        chk("burst_busy_after", busy, 1'b0);

        // reset during DATA bit 3 with two bytes buffered
        push_byte(8'h3C, 1'b0, 4);
        push_byte(8'hC3, 1'b0, 4);
        push_byte(8'h5A, 1'b0, 4);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4 * BIT_CLKS + 100) @(posedge clk);
        #1;
        chk("midframe_busy", busy, 1'b1);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b0);
        repeat (3) @(negedge clk);
        #5 rst_n = 1'b1;
        repeat (FRAME + 20) @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 1'b0);
        chk("post_abort_tx", tx, 1'b1);

        // random bytes with random gaps; data wiggles after acceptance
        for (int i = 0; i < 4; i++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 30);
            if ($urandom_range(0, 3) == 0) gap = gap + FRAME + 10;
            push_byte(rb, 1'b0, 3 * FRAME);
            repeat (gap) begin
                @(negedge clk);
                data_valid = 1'b0;
                data = 8'($urandom);
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        data = 8'($urandom);
        wait_idle(6 * FRAME);
        @(negedge clk);
        chk("final_busy", busy, 1'b0);
        chk("final_tx", tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 115200, line bit rate.
REQ-003 Parameter: FIFO_DEPTH, default 4, transmit buffer entries; power of two, minimum 2.
REQ-004 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: data  input  8  byte to transmit.
REQ-007 Port: data_valid  input  1  data is offered this cycle.
REQ-008 Port: ready  output  1  buffer can accept a byte this cycle.
REQ-009 Port: tx  output  1  serial output line, idle high, driven from a flop.
REQ-010 Port: busy  output  1  frame in progress or buffer non-empty.

Function
REQ-011 BIT_CLKS = CLK_FREQ/BAUD_RATE (integer divide, 434 at defaults); every transmitted bit SHALL last exactly BIT_CLKS cycles.
REQ-012 Byte accepted on a rising edge where data_valid && ready; data_valid while ready low SHALL be ignored, with no buffer change.
REQ-013 ready = not full; purely registered or combinational from the occupancy count, never dependent on data_valid.
REQ-014 Buffer: FIFO order; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-015 Push and pop on the same edge: occupancy unchanged, both pointers advance; push to a full buffer cannot occur (ready low).
REQ-016 FSM states: IDLE, START, DATA, [PARITY], STOP.
REQ-017 IDLE: tx=1; if buffer non-empty, pop head into a shift register and go to START on the same edge.
REQ-018 START: tx=0 for BIT_CLKS cycles, then DATA with bit_index=0.
REQ-019 DATA: tx = shift register bit 0, i.e. LSB first, 8 bits of BIT_CLKS cycles each; after bit 7, go to PARITY if compiled in, else STOP.
REQ-020 STOP: tx=1 for BIT_CLKS cycles; at the end, if buffer non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-021 Latency: byte accepted into an empty buffer while IDLE SHALL drive tx low on the 2nd rising edge after the acceptance edge.
REQ-022 Baud counter reloads to 0 on every state transition; the bit boundary is reached at count BIT_CLKS-1.
REQ-023 busy = (state != IDLE) || (occupancy != 0); busy deasserts in the cycle after the final stop-bit cycle when the buffer is empty.
REQ-024 data is sampled only on the acceptance edge; later changes on data SHALL NOT affect queued or in-flight bytes.

Reset
REQ-025 rst_n low SHALL immediately force: tx=1, state=IDLE, occupancy=0, pointers=0, baud counter=0, bit_index=0, busy=0, ready=0.
REQ-026 ready SHALL rise on the first clock edge after rst_n deassertion.
REQ-027 Reset mid-frame SHALL abort the frame (tx high at once) and discard all buffered bytes.

Configuration
REQ-028 Macro UART_TX_PARITY_EN: when defined, PARITY state sends an even-parity bit (XOR of the 8 data bits) for BIT_CLKS cycles between DATA and STOP, giving an 11-bit frame; when undefined, the PARITY state and its logic are absent, giving a 10-bit frame.

Verification
REQ-029 Defaults, no parity: push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 434 cycles; frame total 4340 cycles; busy low afterwards.
REQ-030 Parity enabled: push 0xA5 -> parity bit 0; push 0x01 -> parity bit 1; frame total 4774 cycles.
REQ-031 Hold data_valid high with 0x10..0x17 -> ready drops after 5 acceptances (4 buffered plus 1 in shift register); all 8 bytes appear in order, with stop-to-start back-to-back and no idle cycles.
REQ-032 Push into an empty buffer at edge N -> tx falls at edge N+2; ready stays high.
REQ-033 Assert rst_n low during DATA bit 3 with 2 bytes buffered -> tx=1 immediately; after release, no frame is emitted and busy=0.
REQ-034 data_valid while full with data 0xFF -> byte is dropped; output sequence is unchanged.
